// File: rtl/micro_seq_pkg.sv
// Shared encodings for the microprogram sequencer: sequencing modes,
// condition-flag indices and the default control-store address width.
package micro_seq_pkg;

    localparam int DEF_STATE_W = 7;

    typedef enum logic [2:0] {
        SEQ_INC      = 3'b000,
        SEQ_JUMP     = 3'b001,
        SEQ_DECODE   = 3'b010,
        SEQ_BRANCH   = 3'b011,
        SEQ_CALL     = 3'b100,
        SEQ_RETURN   = 3'b101,
        SEQ_WAIT_MEM = 3'b110,
        SEQ_HOLD     = 3'b111
    } seq_sel_t;

    localparam logic [1:0] COND_Z = 2'd0;
    localparam logic [1:0] COND_V = 2'd1;
    localparam logic [1:0] COND_N = 2'd2;
    localparam logic [1:0] COND_C = 2'd3;

endpackage

// File: rtl/micro_return_stack.sv
// LIFO of micro-subroutine return addresses. Ignores push when full and pop
// when empty; the sequencer decides what those conditions mean.
module micro_return_stack #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 7,
    localparam int DEPTH_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DEPTH_W-1:0] depth,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] entry [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx   = IDX_W'(depth);
    assign rd_idx   = IDX_W'(depth - 1'b1);
    assign full     = (depth == DEPTH_W'(DEPTH));
    assign empty    = (depth == '0);
    assign data_out = entry[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

    // Storage needs no reset: only entries below depth are ever read.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            entry[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Control-store address sequencer: picks the next microword address from the
// active microword's sequencing fields, flags, decoder entry and memory ready.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 15,
    parameter int RESET_STATE = 0,
    parameter int FAULT_STATE = 127,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         next_sel,
    input  logic [STATE_W-1:0] target,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic [3:0]         cond_in,
    input  logic [STATE_W-1:0] decode_state,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] current_state,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_err,
    output logic               timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STATE_W-1:0] RST_ADDR   = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FAULT_ADDR = STATE_W'(FAULT_STATE);
    localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    seq_sel_t           sel;
    logic [STATE_W-1:0] state_nxt;
    logic [STATE_W-1:0] inc;
    logic [STATE_W-1:0] stack_out;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_nxt;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               cond;
    logic               stack_err_set;
    logic               timeout_set;

    assign sel  = seq_sel_t'(next_sel);
    assign inc  = current_state + 1'b1;
    assign cond = cond_in[cond_sel] ^ cond_inv;

    micro_return_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (STATE_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (inc),
        .data_out (stack_out),
        .depth    (stack_depth),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= RST_ADDR;
            wait_cnt      <= '0;
            stack_err     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            current_state <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            stack_err     <= stack_err | stack_err_set;
            timeout_err   <= timeout_err | timeout_set;
        end
    end

    always_comb begin
        state_nxt     = inc;
        wait_cnt_nxt  = '0;
        push          = 1'b0;
        pop           = 1'b0;
        stack_err_set = 1'b0;
        timeout_set   = 1'b0;
        unique case (sel)
            SEQ_INC:    state_nxt = inc;
            SEQ_JUMP:   state_nxt = target;
            SEQ_DECODE: state_nxt = decode_state;
            SEQ_BRANCH: state_nxt = cond ? target : inc;
            SEQ_CALL: begin
                if (full) begin
                    stack_err_set = 1'b1;
                    state_nxt     = FAULT_ADDR;
                end else begin
                    push      = 1'b1;
                    state_nxt = target;
                end
            end
            SEQ_RETURN: begin
                if (empty) begin
                    stack_err_set = 1'b1;
                    state_nxt     = FAULT_ADDR;
                end else begin
                    pop       = 1'b1;
                    state_nxt = stack_out;
                end
            end
            SEQ_WAIT_MEM: begin
                if (mem_ready) begin
                    state_nxt = inc;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Counter value TIMEOUT-1 is the last cycle allowed in one wait.
                    state_nxt   = FAULT_ADDR;
                    timeout_set = 1'b1;
                end else begin
                    state_nxt    = current_state;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            SEQ_HOLD:   state_nxt = current_state;
            default:    state_nxt = inc;
        endcase
    end

endmodule
